temp_bcd_converter: RTL

Parametrised successor to the station temperature converter. Captures one unsigned XADC sample when the rover reports the correct station, divides it by a fixed scale factor using repeated subtraction, and presents the quotient as a DIGITS-wide BCD word for the 7-segment module. Adds four things over the previous generation:
- configurable input width, digit count and scale;
- saturation with an overflow flag;
- a periodic refresh mode;
- explicit busy/done status.

---
 rtl/temp_bcd_converter_if.sv | 25 ++
 rtl/temp_bcd_converter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_converter_if.sv
// Sample-in / BCD-out bundle of the temperature converter.
// master drives the station/ADC side; slave is the converter.
interface temp_bcd_converter_if #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned DIGITS = 2
);
  logic                  enable;
  logic [IN_W-1:0]       sample;
  logic                  sample_valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  display;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output enable, sample, sample_valid,
    input  bcd, display, busy, done, overflow
  );

  modport slave (
    input  enable, sample, sample_valid,
    output bcd, display, busy, done, overflow
  );
endinterface

// File: rtl/temp_bcd_converter.sv
// Captures an XADC sample, divides by DIVISOR via repeated subtraction and shows the
// saturated quotient as a DIGITS-wide BCD word, optionally re-sampling every REFRESH_CYCLES.
module temp_bcd_converter #(
  parameter int unsigned IN_W           = 12,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned DIVISOR        = 68,
  parameter logic [3:0]  BLANK          = 4'hF,
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  temp_bcd_converter_if.slave  conv_io
);

  localparam int unsigned   BcdW      = 4 * DIGITS;
  localparam int unsigned   CntW      = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam logic [63:0]   MaxDiv    = (64'd1 << IN_W) - 64'd1;
  localparam logic [IN_W-1:0] Div     = IN_W'(DIVISOR);
  localparam logic [BcdW-1:0] BlankWord = {DIGITS{BLANK}};
  localparam logic [CntW-1:0] RefreshCnt = CntW'(REFRESH_CYCLES);

  if (DIVISOR < 1 || 64'(DIVISOR) > MaxDiv) begin : g_bad_divisor
    $error("DIVISOR must lie in 1 .. 2**IN_W-1");
  end
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("DIGITS must lie in 1 .. 4");
  end

  typedef enum logic [2:0] {StIdle, StWait, StDivide, StOutput, StHold} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] rem_q, rem_d;
  logic [BcdW-1:0] quot_q, quot_d;
  logic            sat_q, sat_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [BcdW-1:0] quot_inc;
  logic            all_nines;
  logic [IN_W-1:0] rem_sub;

  // Ripple BCD increment; all_nines doubles as the carry and ends high only for 99..9.
  always_comb begin
    quot_inc  = quot_q;
    all_nines = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (all_nines) begin
        if (quot_q[4*i +: 4] == 4'd9) begin
          quot_inc[4*i +: 4] = 4'd0;
        end else begin
          quot_inc[4*i +: 4] = quot_q[4*i +: 4] + 4'd1;
          all_nines          = 1'b0;
        end
      end
    end
  end

  assign rem_sub = rem_q - Div;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (conv_io.enable) begin
          state_d = StWait;
          bcd_d   = BlankWord;
        end
      end
      StWait: begin
        if (!conv_io.enable) begin
          state_d = StIdle;
          bcd_d   = BlankWord;
          ovf_d   = 1'b0;
        end else if (conv_io.sample_valid) begin
          rem_d   = conv_io.sample;
          quot_d  = '0;
          sat_d   = 1'b0;
          state_d = (conv_io.sample >= Div) ? StDivide : StOutput;
        end
      end
      StDivide: begin
        if (!conv_io.enable) begin
          state_d = StIdle;
          bcd_d   = BlankWord;
          ovf_d   = 1'b0;
        end else if (rem_q < Div) begin
          state_d = StOutput;
        end else if (all_nines) begin
          // Quotient cannot grow any further: freeze it and flag saturation.
          sat_d   = 1'b1;
          state_d = StOutput;
        end else begin
          rem_d  = rem_sub;
          quot_d = quot_inc;
          if (rem_sub < Div) begin
            state_d = StOutput;
          end
        end
      end
      StOutput: begin
        bcd_d   = quot_q;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StHold;
      end
      StHold: begin
        if (!conv_io.enable) begin
          state_d = StIdle;
        end else if (REFRESH_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
          // Re-sample without blanking so the previous reading stays on display.
          if (cnt_d == RefreshCnt) begin
            state_d = StWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quot_q  <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= BlankWord;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign conv_io.bcd      = bcd_q;
  assign conv_io.done     = done_q;
  assign conv_io.overflow = ovf_q;
  assign conv_io.display  = conv_io.enable;
  assign conv_io.busy     = (state_q == StWait) || (state_q == StDivide) ||
                            (state_q == StOutput);

endmodule
